// File: rtl/jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter
//
// Purpose:
//   Arbitrates two requesters that post JK commands (hold/clear/set/toggle)
//   against single bits of an internally owned flip-flop bank. Each command
//   runs a four-phase req/ack handshake: grant, one execute cycle, then ack
//   held until the winner drops its request. A 7-segment digit shows how
//   many bank bits are currently set.
//
// Configuration macro:
//   JK_ARB_RR_EN  defined   -> round-robin between simultaneous requesters
//                 undefined -> fixed priority, requester 0 wins ties
//
// Parameters:
//   N_BITS  bank width (2..8)
//   INIT    bank value loaded on reset
//   AW      address width, $clog2(N_BITS)
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   req[1:0]         request per requester
//   op0/op1          JK code {J,K}: 00 hold, 01 clear, 10 set, 11 toggle
//   addr0/addr1      target bit index per requester
//   gnt[1:0]         one-hot grant (registered)
//   ack[1:0]         per-requester acknowledge (registered)
//   err              address out of range, valid while ack is high
//   q                bank state (registered)
//   display7Segment  active-low {g,f,e,d,c,b,a} showing popcount(q)
// ---------------------------------------------------------------------------
module jk_bank_arbiter #(
   parameter  int                N_BITS = 4,
   parameter  logic [N_BITS-1:0] INIT   = '0,
   localparam int                AW     = $clog2(N_BITS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        op0,
   input  logic [1:0]        op1,
   input  logic [AW-1:0]     addr0,
   input  logic [AW-1:0]     addr1,
   output logic [1:0]        gnt,
   output logic [1:0]        ack,
   output logic              err,
   output logic [N_BITS-1:0] q,
   output logic [6:0]        display7Segment
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        ack_q, ack_d;
   logic              err_q, err_d;
   logic [N_BITS-1:0] bank_q, bank_d;
   logic              win_q, win_d;
   logic [1:0]        op_q, op_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [N_BITS-1:0] bit_mask;
   logic              sel;
   logic [3:0]        ones;

`ifdef JK_ARB_RR_EN
   logic              ptr_q, ptr_d;
`endif

   // Winner selection for the IDLE cycle. A lone request always wins; on a
   // tie either the round-robin pointer or requester 0 decides.
   always_comb begin
`ifdef JK_ARB_RR_EN
      if (req == 2'b11) begin
         sel = ptr_q;
      end else begin
         sel = req[1];
      end
`else
      sel = ~req[0];
`endif
   end

   // Next-state logic for the handshake sequencer and the bank. The bit mask
   // shifts out to zero for addresses beyond the bank, so an out-of-range
   // command can never touch q even before the err check.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ack_d    = ack_q;
      err_d    = err_q;
      bank_d   = bank_q;
      win_d    = win_q;
      op_d     = op_q;
      addr_d   = addr_q;
`ifdef JK_ARB_RR_EN
      ptr_d    = ptr_q;
`endif
      bit_mask = N_BITS'(1) << addr_q;

      unique case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               win_d   = sel;
               op_d    = sel ? op1 : op0;
               addr_d  = sel ? addr1 : addr0;
               gnt_d   = sel ? 2'b10 : 2'b01;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (int'(addr_q) < N_BITS) begin
               unique case (op_q)
                  2'b01:   bank_d = bank_q & ~bit_mask;
                  2'b10:   bank_d = bank_q | bit_mask;
                  2'b11:   bank_d = bank_q ^ bit_mask;
                  default: bank_d = bank_q;
               endcase
            end else begin
               err_d = 1'b1;
            end
            ack_d   = win_q ? 2'b10 : 2'b01;
            state_d = ACK;
         end
         ACK: begin
            if (!req[win_q]) begin
               gnt_d   = 2'b00;
               ack_d   = 2'b00;
               err_d   = 1'b0;
`ifdef JK_ARB_RR_EN
               ptr_d   = ~win_q;
`endif
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state lives here; reset wins in any state, so a command caught in
   // EXEC is dropped rather than applied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         ack_q   <= 2'b00;
         err_q   <= 1'b0;
         bank_q  <= INIT;
         win_q   <= 1'b0;
         op_q    <= 2'b00;
         addr_q  <= '0;
`ifdef JK_ARB_RR_EN
         ptr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         bank_q  <= bank_d;
         win_q   <= win_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
`ifdef JK_ARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Popcount of the bank decoded straight to active-low segments, with no
   // register stage so the digit tracks q in the same cycle.
   always_comb begin
      ones = 4'd0;
      for (int i = 0; i < N_BITS; i++) begin
         ones = ones + {3'b000, bank_q[i]};
      end
      unique case (ones)
         4'd0:    display7Segment = 7'b1000000;
         4'd1:    display7Segment = 7'b1111001;
         4'd2:    display7Segment = 7'b0100100;
         4'd3:    display7Segment = 7'b0110000;
         4'd4:    display7Segment = 7'b0011001;
         4'd5:    display7Segment = 7'b0010010;
         4'd6:    display7Segment = 7'b0000010;
         4'd7:    display7Segment = 7'b1111000;
         4'd8:    display7Segment = 7'b0000000;
         default: display7Segment = 7'b1111111;
      endcase
   end

   assign gnt = gnt_q;
   assign ack = ack_q;
   assign err = err_q;
   assign q   = bank_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_arbiter
//
// Drives a 6-bit bank (so addresses 6 and 7 are out of range) through
// directed handshakes and a randomized requester phase. A transaction-level
// model of the arbiter predicts gnt/ack/err/q/display every cycle; literal
// expectations from hand calculation pin the model in the directed part.
// ---------------------------------------------------------------------------
module tb_jk_bank_arbiter;

   localparam int            N        = 6;
   localparam logic [N-1:0]  INIT_VAL = 6'b000101;
`ifdef JK_ARB_RR_EN
   localparam bit            RR       = 1'b1;
`else
   localparam bit            RR       = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst   = 1'b0;
   logic [1:0]   req   = 2'b00;
   logic [1:0]   op0   = 2'b00;
   logic [1:0]   op1   = 2'b00;
   logic [2:0]   addr0 = 3'd0;
   logic [2:0]   addr1 = 3'd0;
   logic [1:0]   gnt;
   logic [1:0]   ack;
   logic         err;
   logic [N-1:0] q;
   logic [6:0]   seg;

   int checks = 0;
   int errors = 0;

   jk_bank_arbiter #(
      .N_BITS (N),
      .INIT   (INIT_VAL)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req             (req),
      .op0             (op0),
      .op1             (op1),
      .addr0           (addr0),
      .addr1           (addr1),
      .gnt             (gnt),
      .ack             (ack),
      .err             (err),
      .q               (q),
      .display7Segment (seg)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Transaction-level model: who owns the bank (-1 for nobody), whether the
   // command has been executed yet, and the bank as a plain bit array.
   logic [N-1:0] mBank;
   int           mOwner;
   bit           mDone;
   logic [1:0]   mOp;
   int           mAddr;
   int           mPtr;
   logic [1:0]   mGnt;
   logic [1:0]   mAck;
   logic         mErr;
   logic [6:0]   segTable [9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                  7'b0110000, 7'b0011001, 7'b0010010,
                                  7'b0000010, 7'b1111000, 7'b0000000};

   task automatic modelReset();
      mBank  = INIT_VAL;
      mOwner = -1;
      mDone  = 1'b0;
      mOp    = 2'b00;
      mAddr  = 0;
      mPtr   = 0;
      mGnt   = 2'b00;
      mAck   = 2'b00;
      mErr   = 1'b0;
   endtask

   task automatic modelStep();
      int w;
      if (mOwner < 0) begin
         if (req != 2'b00) begin
            if (req == 2'b11) w = RR ? mPtr : 0;
            else              w = req[1] ? 1 : 0;
            mOwner = w;
            mDone  = 1'b0;
            mOp    = (w == 1) ? op1 : op0;
            mAddr  = (w == 1) ? int'(addr1) : int'(addr0);
            mGnt   = (w == 1) ? 2'b10 : 2'b01;
         end
      end else if (!mDone) begin
         if (mAddr < N) begin
            case (mOp)
               2'b01:   mBank[mAddr] = 1'b0;
               2'b10:   mBank[mAddr] = 1'b1;
               2'b11:   mBank[mAddr] = ~mBank[mAddr];
               default: ;
            endcase
         end else begin
            mErr = 1'b1;
         end
         mAck  = mGnt;
         mDone = 1'b1;
      end else if (!req[mOwner]) begin
         mGnt   = 2'b00;
         mAck   = 2'b00;
         mErr   = 1'b0;
         mPtr   = 1 - mOwner;
         mOwner = -1;
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   task automatic checkOutput();
      checkValue("gnt", 32'(gnt), 32'(mGnt));
      checkValue("ack", 32'(ack), 32'(mAck));
      checkValue("err", 32'(err), 32'(mErr));
      checkValue("q",   32'(q),   32'(mBank));
      checkValue("seg", 32'(seg), 32'(segTable[$countones(mBank)]));
   endtask

   // Model advance and compare process; inputs only change on negedges, so
   // what the model reads at posedge is what the DUT sampled.
   always @(posedge clk or posedge rst) begin
      if (rst) modelReset();
      else     modelStep();
      #1;
      checkOutput();
   end

   task automatic applyStimulus(input logic [1:0] r, input logic [1:0] o0, input logic [2:0] a0,
                                input logic [1:0] o1, input logic [2:0] a1);
      @(negedge clk);
      req   = r;
      op0   = o0;
      addr0 = a0;
      op1   = o1;
      addr1 = a1;
   endtask

   // Bounded wait on the model's ack for one requester; returns on a negedge.
   task automatic waitAck(input int who);
      int n;
      n = 0;
      while (!mAck[who] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!mAck[who]) checkValue("ack_timeout", 32'd0, 32'd1);
   endtask

   // One full handshake for a single requester, ending back in IDLE.
   task automatic doHandshake(input int who, input logic [1:0] op, input logic [2:0] addr);
      if (who == 0) applyStimulus(2'b01, op, addr, 2'b00, 3'd0);
      else          applyStimulus(2'b10, 2'b00, 3'd0, op, addr);
      waitAck(who);
      req = 2'b00;
      @(negedge clk);
   endtask

   logic [1:0] tieExp [3];

   initial begin
      $display("[TB] start, round-robin=%0d", RR);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);

      // Reset values.
      checkValue("rst_q",   32'(q),   32'(6'b000101));
      checkValue("rst_gnt", 32'(gnt), 32'd0);
      checkValue("rst_ack", 32'(ack), 32'd0);
      checkValue("rst_seg", 32'(seg), 32'(7'b0100100));
      rst = 1'b0;

      // Single set on bit 3; op/addr changes after the grant must be ignored.
      applyStimulus(2'b01, 2'b10, 3'd3, 2'b00, 3'd0);
      @(negedge clk);
      checkValue("set_gnt", 32'(gnt), 32'(2'b01));
      checkValue("set_ack_early", 32'(ack), 32'd0);
      op0   = 2'b01;
      addr0 = 3'd0;
      @(negedge clk);
      checkValue("set_q",   32'(q),   32'(6'b001101));
      checkValue("set_ack", 32'(ack), 32'(2'b01));
      checkValue("set_seg", 32'(seg), 32'(7'b0110000));
      @(negedge clk);
      checkValue("set_ack_hold", 32'(ack), 32'(2'b01));
      req = 2'b00;
      @(negedge clk);
      checkValue("set_ack_rel", 32'(ack), 32'd0);
      checkValue("set_gnt_rel", 32'(gnt), 32'd0);

      // Toggle bit 4 twice from requester 1.
      doHandshake(1, 2'b11, 3'd4);
      checkValue("tog1_q",   32'(q),   32'(6'b011101));
      checkValue("tog1_seg", 32'(seg), 32'(7'b0011001));
      doHandshake(1, 2'b11, 3'd4);
      checkValue("tog2_q",   32'(q),   32'(6'b001101));
      checkValue("tog2_seg", 32'(seg), 32'(7'b0110000));

      // Simultaneous requests; last completed handshake was requester 1.
      tieExp[0] = 2'b01;
      tieExp[1] = RR ? 2'b10 : 2'b01;
      tieExp[2] = 2'b01;
      applyStimulus(2'b11, 2'b00, 3'd0, 2'b00, 3'd1);
      for (int k = 0; k < 3; k++) begin
         int n;
         int w;
         n = 0;
         while (mGnt == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
         end
         checkValue("tie_gnt", 32'(gnt), 32'(tieExp[k]));
         w = mGnt[1] ? 1 : 0;
         waitAck(w);
         req[w] = 1'b0;
         @(negedge clk);
         req = 2'b11;
      end
      req = 2'b00;
      repeat (4) @(negedge clk);

      // Out-of-range address on the 6-bit bank.
      applyStimulus(2'b01, 2'b10, 3'd7, 2'b00, 3'd0);
      waitAck(0);
      checkValue("oor_err", 32'(err), 32'd1);
      checkValue("oor_q",   32'(q),   32'(6'b001101));
      req = 2'b00;
      @(negedge clk);
      checkValue("oor_err_rel", 32'(err), 32'd0);

      // Reset caught during EXEC, then a fresh request.
      applyStimulus(2'b01, 2'b10, 3'd1, 2'b00, 3'd0);
      @(negedge clk);
      checkValue("mid_gnt_pre", 32'(gnt), 32'(2'b01));
      rst = 1'b1;
      #1;
      checkValue("mid_q",   32'(q),   32'(INIT_VAL));
      checkValue("mid_gnt", 32'(gnt), 32'd0);
      checkValue("mid_ack", 32'(ack), 32'd0);
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      doHandshake(0, 2'b10, 3'd1);
      checkValue("post_q", 32'(q), 32'(6'b000111));

      // Randomized requesters: raise with random commands, drop after ack,
      // occasionally drop early, and scribble op/addr every cycle.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!req[i]) begin
               if ($urandom_range(2) == 0) req[i] = 1'b1;
            end else if (mAck[i]) begin
               if ($urandom_range(1) == 0) req[i] = 1'b0;
            end else if ($urandom_range(39) == 0) begin
               req[i] = 1'b0;
            end
         end
         op0   = 2'($urandom_range(3));
         op1   = 2'($urandom_range(3));
         addr0 = 3'($urandom_range(7));
         addr1 = 3'($urandom_range(7));
      end
      req = 2'b00;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
